quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter COUNT_WIDTH, default 32, width of position counter (8..64).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops per raw input (2..4).
REQ-003 Parameter FILTER_LEN, default 4, consecutive stable samples needed to accept a new input level (1..16).
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sig_a, sig_b  input  1 each  raw asynchronous encoder channels.
REQ-007 sig_z  input  1  raw asynchronous index channel.
REQ-008 mode  input  2  resolution select: 00 X4, 01 X2, 10 X1, 11 treated as X4.
REQ-009 index_clear_en  input  1  when high, a filtered index rising edge zeroes the count.
REQ-010 load, load_value  input  1 / COUNT_WIDTH  synchronous count preset.
REQ-011 err_clear  input  1  clears illegal_err and index_seen.
REQ-012 encoder_count  output  COUNT_WIDTH  signed two's-complement position.
REQ-013 step  output  1  one-cycle pulse per counted transition.
REQ-014 direction  output  1  1 = last counted step was forward, 0 = reverse.
REQ-015 illegal_err, index_seen  output  1 each  sticky status flags.

Function
REQ-016 Each raw input passes through SYNC_STAGES flops, then a filter that changes its output only after the synchronised value differs from it for FILTER_LEN consecutive cycles; a shorter glitch resets the filter's run counter.
REQ-017 Gray states {a,b}: S0=00, S1=01, S2=11, S3=10; forward = S0>S1>S2>S3>S0; reverse is the opposite.
REQ-018 Decoder registers the current and previous filtered state each cycle; no change = no action.
REQ-019 X4 counts every legal transition; X2 counts only transitions where a changes (S1<>S2, S3<>S0); X1 counts only S3<>S0.
REQ-020 Counted forward transition: count +1, direction <= 1; counted reverse: count -1, direction <= 0; step pulses high for exactly that cycle.
REQ-021 Uncounted legal transitions (X2/X1) leave count, step and direction unchanged.
REQ-022 Double-bit change (S0<>S2, S1<>S3): no count, no step, illegal_err <= 1.
REQ-023 Count wraps modulo 2^COUNT_WIDTH in both directions; no saturation.
REQ-024 Index event = rising edge of filtered z; sets index_seen; if index_clear_en, count <= 0 that cycle.
REQ-025 Count priority: reset > load > index clear > step; a suppressed step still drives step and direction.
REQ-026 Sticky flags: a set event in the same cycle as err_clear wins (flag stays 1).
REQ-027 Latency: count updates SYNC_STAGES+FILTER_LEN+1 clk edges after the first edge sampling a new raw level (7 at defaults).
REQ-028 mode changes take effect on the next decoded transition; no count correction.

Reset
REQ-029 On reset: encoder_count=0, step=0, direction=0, illegal_err=0, index_seen=0; synchroniser, filter outputs and run counters cleared.
REQ-030 For SYNC_STAGES+FILTER_LEN+1 cycles after reset deasserts, the decoder primes: it tracks state but counts nothing and flags nothing.
REQ-031 Reset asserted mid-transition discards all in-flight samples; behaviour is then as in REQ-029/030.

Structure
REQ-032 Package quad_pkg holds the Gray state enum and the mode enum with encodings above.
REQ-033 Sub-module quad_input_filter (synchroniser plus run-length filter, parameters SYNC_STAGES, FILTER_LEN) is instantiated three times (a, b, z).

Verification
REQ-034 Defaults, X4, 8 forward steps spaced 20 cycles -> count=8, 8 step pulses, direction=1, each update 7 cycles after the raw edge.
REQ-035 Count=0, one reverse step in X4 -> count=all-ones (-1); load 0x7FFFFFFF, one forward step -> 0x80000000.
REQ-036 X1, one full forward cycle (4 transitions) -> count +1, exactly one step; X2 -> +2, two steps.
REQ-037 3-cycle glitch on sig_a (FILTER_LEN=4) -> no count, no step; a and b toggled on the same cycle -> illegal_err=1, count unchanged; err_clear -> 0.
REQ-038 index_clear_en=1, z rising on the same filtered cycle as a forward step at count=5 -> count=0, step=1, direction=1, index_seen=1.
REQ-039 Inputs held at 11 through reset -> after priming, count=0, illegal_err=0.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types for the quadrature decoder: Gray-coded encoder states and resolution modes.
package quad_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b11,
        S3 = 2'b10
    } quad_state_t;

    typedef enum logic [1:0] {
        MODE_X4     = 2'b00,
        MODE_X2     = 2'b01,
        MODE_X1     = 2'b10,
        MODE_X4_ALT = 2'b11
    } quad_mode_t;

    // Forward successor of a Gray state.
    function automatic quad_state_t gray_next(input quad_state_t s);
        case (s)
            S0:      return S1;
            S1:      return S2;
            S2:      return S3;
            default: return S0;
        endcase
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Synchroniser chain followed by a run-length filter for one raw asynchronous input.
module quad_input_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int unsigned RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [RUN_W-1:0]       run_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Output follows only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q    <= '0;
            filtered <= 1'b0;
        end else if (synced == filtered) begin
            run_q <= '0;
        end else if (run_q == RUN_W'(FILTER_LEN - 1)) begin
            run_q    <= '0;
            filtered <= synced;
        end else begin
            run_q <= run_q + RUN_W'(1);
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: filtered A/B/Z inputs, X4/X2/X1 counting, index clear and sticky status.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sig_a,
    input  logic                   sig_b,
    input  logic                   sig_z,
    input  logic [1:0]             mode,
    input  logic                   index_clear_en,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_value,
    input  logic                   err_clear,
    output logic [COUNT_WIDTH-1:0] encoder_count,
    output logic                   step,
    output logic                   direction,
    output logic                   illegal_err,
    output logic                   index_seen
);

    localparam int unsigned PRIME_LEN = SYNC_STAGES + FILTER_LEN + 1;
    localparam int unsigned PRIME_W   = $clog2(PRIME_LEN + 1);

    logic a_f, b_f, z_f;

    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .reset(reset), .raw(sig_a), .filtered(a_f)
    );
    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .reset(reset), .raw(sig_b), .filtered(b_f)
    );
    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_z (
        .clk(clk), .reset(reset), .raw(sig_z), .filtered(z_f)
    );

    quad_state_t          cur_s, prev_s;
    logic                 z_q;
    logic [PRIME_W-1:0]   prime_cnt;
    logic [1:0]           diff;
    logic                 primed, fwd, illegal_c, mode_hit, step_c, index_c, x1_edge;

    assign cur_s = quad_state_t'({a_f, b_f});

    // Classify the filtered transition and decide whether the current mode counts it.
    always_comb begin
        diff      = 2'(cur_s ^ prev_s);
        primed    = (prime_cnt == '0);
        fwd       = (cur_s == gray_next(prev_s));
        x1_edge   = ((prev_s == S3) && (cur_s == S0)) || ((prev_s == S0) && (cur_s == S3));
        mode_hit  = 1'b1;
        case (quad_mode_t'(mode))
            MODE_X2: mode_hit = diff[1];
            MODE_X1: mode_hit = x1_edge;
            default: mode_hit = 1'b1;
        endcase
        illegal_c = primed && (diff == 2'b11);
        step_c    = primed && (diff != 2'b00) && (diff != 2'b11) && mode_hit;
        index_c   = primed && z_f && !z_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_s        <= S0;
            z_q           <= 1'b0;
            prime_cnt     <= PRIME_W'(PRIME_LEN);
            encoder_count <= '0;
            step          <= 1'b0;
            direction     <= 1'b0;
            illegal_err   <= 1'b0;
            index_seen    <= 1'b0;
        end else begin
            prev_s <= cur_s;
            z_q    <= z_f;
            if (prime_cnt != '0) begin
                prime_cnt <= prime_cnt - PRIME_W'(1);
            end
            step <= step_c;
            if (step_c) begin
                direction <= fwd;
            end
            // Load beats index clear beats the step itself; step/direction still report.
            if (load) begin
                encoder_count <= load_value;
            end else if (index_c && index_clear_en) begin
                encoder_count <= '0;
            end else if (step_c) begin
                encoder_count <= fwd ? encoder_count + COUNT_WIDTH'(1)
                                     : encoder_count - COUNT_WIDTH'(1);
            end
            illegal_err <= illegal_c | (illegal_err & ~err_clear);
            index_seen  <= index_c   | (index_seen  & ~err_clear);
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus randomized moves against a position model.
module tb_quad_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sig_a, sig_b, sig_z;
    logic [1:0]  mode;
    logic        index_clear_en, load, err_clear;
    logic [31:0] load_value;
    logic [31:0] encoder_count;
    logic        step, direction, illegal_err, index_seen;

    quad_decoder dut (
        .clk(clk), .reset(reset), .sig_a(sig_a), .sig_b(sig_b), .sig_z(sig_z),
        .mode(mode), .index_clear_en(index_clear_en), .load(load), .load_value(load_value),
        .err_clear(err_clear), .encoder_count(encoder_count), .step(step),
        .direction(direction), .illegal_err(illegal_err), .index_seen(index_seen)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int step_seen = 0;

    // Model: encoder angle as position 0..3 in Gray order plus expected outputs.
    logic [1:0]  gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int          pos;
    logic [31:0] m_count;
    logic        m_dir, m_ill, m_idx;

    always @(posedge clk) if (step === 1'b1) step_seen <= step_seen + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int p);
        reset = 1'b1;
        pos = p;
        {sig_a, sig_b} = gray[p];
        sig_z = 1'b0; load = 1'b0; err_clear = 1'b0;
        tick(3);
        reset = 1'b0;
        m_count = '0; m_dir = 1'b0; m_ill = 1'b0; m_idx = 1'b0;
        tick(20);
    endtask

    task automatic do_load(input logic [31:0] v);
        load = 1'b1; load_value = v;
        tick(1);
        load = 1'b0;
        m_count = v;
        n_checks++;
        if (encoder_count !== v) begin
            n_fail++;
            $display("FAIL load: count=%h required=%h", encoder_count, v);
        end
    endtask

    // One encoder move of delta positions (1 fwd, 3 rev, 2 illegal), optionally with z rising.
    task automatic move(input int delta, input bit z_rise, input string tag);
        int np;
        bit legal, fwd, cnt, idx;
        logic [31:0] exp_c;
        np    = (pos + delta) % 4;
        legal = (delta != 2);
        fwd   = (delta == 1);
        case (mode)
            2'b01:   cnt = legal && (gray[pos][1] != gray[np][1]);
            2'b10:   cnt = legal && ((pos == 3 && np == 0) || (pos == 0 && np == 3));
            default: cnt = legal;
        endcase
        idx   = z_rise && !sig_z;
        exp_c = m_count;
        if (idx && index_clear_en) exp_c = '0;
        else if (cnt)              exp_c = fwd ? m_count + 32'd1 : m_count - 32'd1;
        {sig_a, sig_b} = gray[np];
        if (z_rise) sig_z = 1'b1;
        tick(6);
        n_checks++;
        if (step !== 1'b0 || encoder_count !== m_count) begin
            n_fail++;
            $display("FAIL %s early: step=%b count=%h required step=0 count=%h", tag, step, encoder_count, m_count);
        end
        tick(1);
        n_checks++;
        if (step !== cnt) begin
            n_fail++;
            $display("FAIL %s step: got %b required %b", tag, step, cnt);
        end
        n_checks++;
        if (encoder_count !== exp_c) begin
            n_fail++;
            $display("FAIL %s count: got %h required %h", tag, encoder_count, exp_c);
        end
        n_checks++;
        if (direction !== (cnt ? fwd : m_dir)) begin
            n_fail++;
            $display("FAIL %s direction: got %b required %b", tag, direction, cnt ? fwd : m_dir);
        end
        n_checks++;
        if (illegal_err !== (m_ill | !legal) || index_seen !== (m_idx | idx)) begin
            n_fail++;
            $display("FAIL %s flags: ill=%b idx=%b required ill=%b idx=%b", tag, illegal_err, index_seen, m_ill | !legal, m_idx | idx);
        end
        if (cnt) m_dir = fwd;
        m_count = exp_c; m_ill = m_ill | !legal; m_idx = m_idx | idx; pos = np;
        tick(1);
        n_checks++;
        if (step !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse_width: step=%b required 0", tag, step);
        end
        tick(12);
    endtask

    task automatic test_reset();
        do_reset(0);
        n_checks++;
        if (encoder_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %h required 0", encoder_count); end
        n_checks++;
        if (step !== 1'b0 || direction !== 1'b0) begin n_fail++; $display("FAIL reset_step_dir: step=%b dir=%b required 0 0", step, direction); end
        n_checks++;
        if (illegal_err !== 1'b0 || index_seen !== 1'b0) begin n_fail++; $display("FAIL reset_flags: ill=%b idx=%b required 0 0", illegal_err, index_seen); end
    endtask

    task automatic test_x4_forward();
        int s0;
        do_reset(0);
        mode = 2'b00;
        s0 = step_seen;
        for (int i = 0; i < 8; i++) move(1, 1'b0, "x4_fwd");
        n_checks++;
        if (encoder_count !== 32'd8) begin n_fail++; $display("FAIL x4_total: got %h required 8", encoder_count); end
        n_checks++;
        if (step_seen - s0 !== 8) begin n_fail++; $display("FAIL x4_pulses: got %0d required 8", step_seen - s0); end
        n_checks++;
        if (direction !== 1'b1) begin n_fail++; $display("FAIL x4_dir: got %b required 1", direction); end
    endtask

    task automatic test_wrap();
        do_reset(0);
        mode = 2'b00;
        move(3, 1'b0, "wrap_rev");
        n_checks++;
        if (encoder_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_under: got %h required ffffffff", encoder_count); end
        do_load(32'h7FFF_FFFF);
        move(1, 1'b0, "wrap_fwd");
        n_checks++;
        if (encoder_count !== 32'h8000_0000) begin n_fail++; $display("FAIL wrap_signed: got %h required 80000000", encoder_count); end
    endtask

    task automatic test_resolution();
        int s0;
        logic [31:0] c0;
        mode = 2'b10;
        s0 = step_seen; c0 = m_count;
        for (int i = 0; i < 4; i++) move(1, 1'b0, "x1");
        n_checks++;
        if (encoder_count !== c0 + 32'd1 || step_seen - s0 !== 1) begin
            n_fail++; $display("FAIL x1_cycle: count=%h steps=%0d required %h 1", encoder_count, step_seen - s0, c0 + 32'd1);
        end
        mode = 2'b01;
        s0 = step_seen; c0 = m_count;
        for (int i = 0; i < 4; i++) move(1, 1'b0, "x2");
        n_checks++;
        if (encoder_count !== c0 + 32'd2 || step_seen - s0 !== 2) begin
            n_fail++; $display("FAIL x2_cycle: count=%h steps=%0d required %h 2", encoder_count, step_seen - s0, c0 + 32'd2);
        end
        mode = 2'b00;
    endtask

    task automatic test_glitch_illegal();
        int s0;
        s0 = step_seen;
        sig_a = ~sig_a;
        tick(3);
        sig_a = ~sig_a;
        tick(20);
        n_checks++;
        if (encoder_count !== m_count || step_seen !== s0) begin
            n_fail++; $display("FAIL glitch: count=%h steps=%0d required %h %0d", encoder_count, step_seen, m_count, s0);
        end
        move(2, 1'b0, "illegal");
        err_clear = 1'b1; tick(1); err_clear = 1'b0;
        m_ill = 1'b0; m_idx = 1'b0;
        n_checks++;
        if (illegal_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b required 0", illegal_err); end
        // Set event while err_clear is held: set must win.
        err_clear = 1'b1;
        move(2, 1'b0, "set_wins");
        err_clear = 1'b0;
        m_ill = 1'b0;
        n_checks++;
        if (illegal_err !== 1'b0) begin n_fail++; $display("FAIL held_clear: got %b required 0", illegal_err); end
    endtask

    task automatic test_index();
        mode = 2'b00;
        index_clear_en = 1'b1;
        do_load(32'd5);
        move(1, 1'b1, "index");
        n_checks++;
        if (encoder_count !== 32'd0 || step !== 1'b0 || direction !== 1'b1 || index_seen !== 1'b1) begin
            n_fail++; $display("FAIL index_final: count=%h dir=%b idx=%b required 0 1 1", encoder_count, direction, index_seen);
        end
        sig_z = 1'b0;
        index_clear_en = 1'b0;
        tick(12);
    endtask

    task automatic test_hold_11_and_mid_reset();
        int s0;
        do_reset(2);
        n_checks++;
        if (encoder_count !== 32'd0 || illegal_err !== 1'b0) begin
            n_fail++; $display("FAIL prime_11: count=%h ill=%b required 0 0", encoder_count, illegal_err);
        end
        move(1, 1'b0, "after_prime");
        s0 = step_seen;
        pos = (pos + 1) % 4;
        {sig_a, sig_b} = gray[pos];
        tick(3);
        reset = 1'b1; tick(2); reset = 1'b0;
        m_count = '0; m_dir = 1'b0; m_ill = 1'b0; m_idx = 1'b0;
        tick(20);
        n_checks++;
        if (encoder_count !== 32'd0 || step_seen !== s0 || illegal_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: count=%h steps=%0d ill=%b required 0 %0d 0", encoder_count, step_seen, illegal_err, s0);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 40; i++) begin
            mode = 2'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            move((r < 5) ? 1 : ((r < 9) ? 3 : 2), 1'b0, "random");
        end
    endtask

    initial begin
        reset = 1'b1; sig_a = 1'b0; sig_b = 1'b0; sig_z = 1'b0; mode = 2'b00;
        index_clear_en = 1'b0; load = 1'b0; load_value = '0; err_clear = 1'b0;
        test_reset();
        test_x4_forward();
        test_wrap();
        test_resolution();
        test_glitch_illegal();
        test_index();
        test_hold_11_and_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
